bp_vc_ctrl: RTL and testbench
=============================

# bp_vc_ctrl

Control and replacement engine for the generic victim cache in the CCE/ME path. It owns the per-entry tag, valid and dirty state, and allocates write slots for lines evicted from the D$. It answers D$ lookups, promoting hit lines back out of the victim cache. It drains dirty victims to the UCE over a valid/ready handshake before they can be overwritten. The victim data array stays in the datapath and is steered by this block's index outputs.

## Interface
- tag_width, 28, line tag width
- num_entries, 4, victim entries; power of two, ≥2
- lg_num_entries, $clog2(num_entries), index width (derived)

- clk_i  in  1  clock
- reset  in  1  asynchronous, active-high reset
- evict_v_i  in  1  D$ presents an evicted line
- evict_tag_i  in  tag_width  tag of evicted line
- evict_dirty_i  in  1  evicted line is dirty
- evict_ready_o  out  1  insert accepted this cycle when high with evict_v_i
- wr_en_o  out  1  write strobe to victim data/stat array
- wr_idx_o  out  lg_num_entries  entry written
- lookup_v_i  in  1  D$ lookup request
- lookup_tag_i  in  tag_width  lookup tag
- hit_o  out  1  lookup hit
- hit_idx_o  out  lg_num_entries  hit entry, selects datapath read mux
- wb_v_o  out  1  writeback request to UCE
- wb_idx_o  out  lg_num_entries  entry being written back
- wb_tag_o  out  tag_width  tag being written back
- wb_ready_i  in  1  UCE accepts writeback

## Operation
- State per entry: tag, valid, dirty. Round-robin pointer rr_ptr (lg_num_entries bits, wraps num_entries-1 -> 0). FSM states: IDLE, WB.
- Lookup: hit_o = lookup_v_i & (some entry valid, tag match, and not the WB entry while in WB). hit_idx_o = matching index (0 on miss). On hit, the entry is invalidated at the next edge; its dirty bit is cleared.
- Insert allocation, priority order:
  1. valid entry whose tag == evict_tag_i (duplicate): overwrite it, dirty <= old dirty | evict_dirty_i;
  2. lowest-index invalid entry;
  3. rr_ptr entry (full case); only legal if that entry is clean. The old line is dropped and rr_ptr increments.
- rr_ptr advances only in case 3.
- evict_ready_o = (state == IDLE) & (duplicate match | any invalid | rr_ptr entry clean).
- wr_en_o = evict_v_i & evict_ready_o; wr_idx_o = allocated index. Tag, valid=1 and dirty update at the edge.
- IDLE -> WB when all entries valid & rr_ptr entry dirty & no insert accepted this cycle. The WB entry index is latched as rr_ptr.
- In WB, wb_v_o=1 with wb_idx_o/wb_tag_o stable until wb_ready_i. On handshake, that entry's dirty clears (stays valid, clean); next state IDLE.
- In WB: inserts are blocked, and lookups to the WB entry miss, so UCE ordering makes the refill see written-back data. Hits to other entries proceed normally.
- Simultaneous hit and insert targeting the same index: hit_o is still reported (datapath reads old data this cycle). The insert wins: the entry ends valid with the new tag and dirty = evict_dirty_i.
- Simultaneous hit on entry X and insert elsewhere: both take effect. Allocation uses pre-edge valid bits; a slot freed by the hit is available next cycle.

## Timing
- Reset (async, immediate): all valid/dirty = 0, rr_ptr = 0, state IDLE.
- Output values during reset: evict_ready_o = 1, wr_en_o = 0, hit_o = 0, wb_v_o = 0. All index and tag outputs are 0.
- hit_o, hit_idx_o, evict_ready_o, wr_en_o, wr_idx_o are combinational, same cycle as the request.
- State updates are visible the cycle after.
- wb_v_o is registered (from state). It asserts 1 cycle after the full-and-dirty condition arises.
- evict_ready_o returns 1 the cycle after the wb handshake.
- Reset asserted mid-WB: wb_v_o drops immediately; the pending writeback is abandoned.

## Test plan
- num_entries=4, clean inserts of tags 0x10,0x11,0x12,0x13 -> wr_idx 0,1,2,3. Fifth insert 0x14 -> wr_idx 0, rr_ptr=1, wb_v_o never asserts.
- Four dirty inserts 0x20–0x23 -> evict_ready_o=0 after the fourth. Next cycle wb_v_o=1, wb_idx_o=0, wb_tag_o=0x20. With wb_ready_i low 3 cycles, outputs are stable. On wb_ready_i=1, the next cycle shows IDLE and evict_ready_o=1, and insert 0x24 -> wr_idx 0.
- After the fill of scenario 1, lookup 0x12 -> hit_o=1, hit_idx_o=2 same cycle. Repeat lookup next cycle -> hit_o=0. Next insert 0x30 -> wr_idx 2, rr_ptr unchanged.
- Insert 0x11 dirty while 0x11 is clean at idx1 -> wr_idx 1, entry 1 dirty, no other entry changes.
- Full clean with rr_ptr=0: lookup of entry 0's tag and insert 0x40 in the same cycle -> hit_o=1, hit_idx_o=0, wr_idx 0. Next cycle entry 0 is valid with tag 0x40.
- Reset pulse during WB (wb_v_o=1) -> wb_v_o=0 and evict_ready_o=1 without a clock edge. A subsequent lookup of any prior tag misses.

Source files
------------

// File: rtl/bp_vc_ctrl.sv
// bp_vc_ctrl: tag/valid/dirty bookkeeping, slot allocation and dirty-victim
// writeback sequencing for the victim cache. Data array lives in the datapath.
module bp_vc_ctrl #(
    parameter int unsigned tag_width      = 28,
    parameter int unsigned num_entries    = 4,
    parameter int unsigned lg_num_entries = $clog2(num_entries)
) (
    input  logic                      clk_i,
    input  logic                      reset,

    input  logic                      evict_v_i,
    input  logic [tag_width-1:0]      evict_tag_i,
    input  logic                      evict_dirty_i,
    output logic                      evict_ready_o,
    output logic                      wr_en_o,
    output logic [lg_num_entries-1:0] wr_idx_o,

    input  logic                      lookup_v_i,
    input  logic [tag_width-1:0]      lookup_tag_i,
    output logic                      hit_o,
    output logic [lg_num_entries-1:0] hit_idx_o,

    output logic                      wb_v_o,
    output logic [lg_num_entries-1:0] wb_idx_o,
    output logic [tag_width-1:0]      wb_tag_o,
    input  logic                      wb_ready_i
);

    typedef enum logic {
        IDLE,
        WB
    } state_e;

    state_e                      state_r;
    logic [tag_width-1:0]        tag_r [num_entries];
    logic [num_entries-1:0]      valid_r;
    logic [num_entries-1:0]      dirty_r;
    logic [lg_num_entries-1:0]   rr_ptr;
    logic [lg_num_entries-1:0]   wb_idx_r;

    logic                        hit_found;
    logic [lg_num_entries-1:0]   hit_idx;
    logic                        dup_found;
    logic [lg_num_entries-1:0]   dup_idx;
    logic                        inv_found;
    logic [lg_num_entries-1:0]   inv_idx;
    logic [lg_num_entries-1:0]   alloc_idx;

    // Lookup match, duplicate-tag match and lowest free slot, all from pre-edge state
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        dup_found = 1'b0;
        dup_idx   = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int unsigned i = 0; i < num_entries; i++) begin
            if (!hit_found && valid_r[i] && (tag_r[i] == lookup_tag_i) &&
                !((state_r == WB) && (wb_idx_r == lg_num_entries'(i)))) begin
                hit_found = 1'b1;
                hit_idx   = lg_num_entries'(i);
            end
            if (!dup_found && valid_r[i] && (tag_r[i] == evict_tag_i)) begin
                dup_found = 1'b1;
                dup_idx   = lg_num_entries'(i);
            end
            if (!inv_found && !valid_r[i]) begin
                inv_found = 1'b1;
                inv_idx   = lg_num_entries'(i);
            end
        end
    end

    assign alloc_idx     = dup_found ? dup_idx : (inv_found ? inv_idx : rr_ptr);
    assign hit_o         = lookup_v_i & hit_found;
    assign hit_idx_o     = hit_o ? hit_idx : '0;
    assign evict_ready_o = (state_r == IDLE) & (dup_found | inv_found | ~dirty_r[rr_ptr]);
    assign wr_en_o       = evict_v_i & evict_ready_o & ~reset;
    assign wr_idx_o      = alloc_idx;
    assign wb_v_o        = (state_r == WB);
    assign wb_idx_o      = wb_v_o ? wb_idx_r : '0;
    assign wb_tag_o      = wb_v_o ? tag_r[wb_idx_r] : '0;

    // Entry state, replacement pointer and writeback FSM
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < num_entries; i++) begin
                tag_r[i] <= '0;
            end
            valid_r  <= '0;
            dirty_r  <= '0;
            rr_ptr   <= '0;
            wb_idx_r <= '0;
            state_r  <= IDLE;
        end else begin
            if (hit_o) begin
                valid_r[hit_idx] <= 1'b0;
                dirty_r[hit_idx] <= 1'b0;
            end
            // Insert is ordered after the hit so it wins on a shared index; a
            // duplicate being promoted at the same time loses its old dirty bit.
            if (wr_en_o) begin
                tag_r[alloc_idx]   <= evict_tag_i;
                valid_r[alloc_idx] <= 1'b1;
                if (dup_found && !(hit_o && (hit_idx == alloc_idx)))
                    dirty_r[alloc_idx] <= dirty_r[alloc_idx] | evict_dirty_i;
                else
                    dirty_r[alloc_idx] <= evict_dirty_i;
                if (!dup_found && !inv_found)
                    rr_ptr <= rr_ptr + lg_num_entries'(1);
            end
            case (state_r)
                IDLE: begin
                    // A line promoted out by a hit this cycle needs no writeback.
                    if ((&valid_r) && dirty_r[rr_ptr] && !wr_en_o &&
                        !(hit_o && (hit_idx == rr_ptr))) begin
                        state_r  <= WB;
                        wb_idx_r <= rr_ptr;
                    end
                end
                WB: begin
                    if (wb_ready_i) begin
                        dirty_r[wb_idx_r] <= 1'b0;
                        state_r           <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_vc_ctrl.sv
// Directed scoreboard bench for bp_vc_ctrl (4 entries, 28-bit tags).
module tb_bp_vc_ctrl;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        evict_v_i = 1'b0;
    logic [27:0] evict_tag_i = '0;
    logic        evict_dirty_i = 1'b0;
    logic        evict_ready_o;
    logic        wr_en_o;
    logic [1:0]  wr_idx_o;
    logic        lookup_v_i = 1'b0;
    logic [27:0] lookup_tag_i = '0;
    logic        hit_o;
    logic [1:0]  hit_idx_o;
    logic        wb_v_o;
    logic [1:0]  wb_idx_o;
    logic [27:0] wb_tag_o;
    logic        wb_ready_i = 1'b0;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    string       name_q [$];
    logic [31:0] val_q  [$];

    bp_vc_ctrl #(.tag_width(28), .num_entries(4)) dut (
        .clk_i         (clk_i),
        .reset         (reset),
        .evict_v_i     (evict_v_i),
        .evict_tag_i   (evict_tag_i),
        .evict_dirty_i (evict_dirty_i),
        .evict_ready_o (evict_ready_o),
        .wr_en_o       (wr_en_o),
        .wr_idx_o      (wr_idx_o),
        .lookup_v_i    (lookup_v_i),
        .lookup_tag_i  (lookup_tag_i),
        .hit_o         (hit_o),
        .hit_idx_o     (hit_idx_o),
        .wb_v_o        (wb_v_o),
        .wb_idx_o      (wb_idx_o),
        .wb_tag_o      (wb_tag_o),
        .wb_ready_i    (wb_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input string n, input logic [31:0] v);
        name_q.push_back(n);
        val_q.push_back(v);
    endtask

    task automatic pop_cmp(input string n, input logic [31:0] obs);
        string       en;
        logic [31:0] ev;
        total_cnt++;
        if (val_q.size() == 0) begin
            $error("FAIL %s observed=%0h required=<scoreboard empty>", n, obs);
        end else begin
            en = name_q.pop_front();
            ev = val_q.pop_front();
            assert (obs === ev) pass_cnt++;
            else $error("FAIL %s observed=%0h required=%0h", en, obs, ev);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ins(input logic [27:0] t, input logic d, input logic [31:0] idx);
        evict_v_i = 1'b1; evict_tag_i = t; evict_dirty_i = d;
        push_exp("ins_ready", 1); push_exp("ins_wr_en", 1); push_exp("ins_wr_idx", idx);
        @(negedge clk_i);
        pop_cmp("ins_ready", {31'd0, evict_ready_o});
        pop_cmp("ins_wr_en", {31'd0, wr_en_o});
        pop_cmp("ins_wr_idx", {30'd0, wr_idx_o});
        tick();
        evict_v_i = 1'b0; evict_dirty_i = 1'b0;
    endtask

    task automatic look(input logic [27:0] t, input logic h, input logic [31:0] idx);
        lookup_v_i = 1'b1; lookup_tag_i = t;
        push_exp("lk_hit", {31'd0, h}); push_exp("lk_hit_idx", idx);
        @(negedge clk_i);
        pop_cmp("lk_hit", {31'd0, hit_o});
        pop_cmp("lk_hit_idx", {30'd0, hit_idx_o});
        tick();
        lookup_v_i = 1'b0;
    endtask

    task automatic wb_chk(input logic v, input logic [31:0] idx, input logic [31:0] t);
        push_exp("wb_v", {31'd0, v}); push_exp("wb_idx", idx); push_exp("wb_tag", t);
        @(negedge clk_i);
        pop_cmp("wb_v", {31'd0, wb_v_o});
        pop_cmp("wb_idx", {30'd0, wb_idx_o});
        pop_cmp("wb_tag", {4'd0, wb_tag_o});
    endtask

    task automatic ready_chk(input logic r, input logic we);
        push_exp("ready", {31'd0, r}); push_exp("wr_en", {31'd0, we});
        pop_cmp("ready", {31'd0, evict_ready_o});
        pop_cmp("wr_en", {31'd0, wr_en_o});
    endtask

    initial begin
        // Reset state, with requests driven to exercise output gating
        evict_v_i = 1'b1; evict_tag_i = 28'h99; lookup_v_i = 1'b1; lookup_tag_i = 28'h0;
        #2;
        ready_chk(1'b1, 1'b0);
        push_exp("rst_hit", 0); pop_cmp("rst_hit", {31'd0, hit_o});
        push_exp("rst_wr_idx", 0); pop_cmp("rst_wr_idx", {30'd0, wr_idx_o});
        push_exp("rst_hit_idx", 0); pop_cmp("rst_hit_idx", {30'd0, hit_idx_o});
        wb_chk(1'b0, 0, 0);
        evict_v_i = 1'b0; lookup_v_i = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Clean fill, then one more insert replaces rr_ptr entry 0
        for (int i = 0; i < 4; i++) ins(28'h10 + 28'(i), 1'b0, 32'(i));
        ins(28'h14, 1'b0, 0);
        wb_chk(1'b0, 0, 0);
        tick();
        wb_chk(1'b0, 0, 0);
        tick();

        // Hit promotes entry 2 out; repeat misses; freed slot reused, rr_ptr stays 1
        look(28'h12, 1'b1, 2);
        look(28'h12, 1'b0, 0);
        ins(28'h30, 1'b0, 2);

        // Duplicate tag merges dirty into entry 1
        ins(28'h11, 1'b1, 1);

        // Full with rr_ptr entry 1 dirty: insert refused, writeback of entry 1 follows
        evict_v_i = 1'b1; evict_tag_i = 28'h50; evict_dirty_i = 1'b0;
        @(negedge clk_i);
        ready_chk(1'b0, 1'b0);
        tick();
        lookup_v_i = 1'b1; lookup_tag_i = 28'h11;
        wb_chk(1'b1, 1, 28'h11);
        ready_chk(1'b0, 1'b0);
        push_exp("wb_entry_miss", 0); pop_cmp("wb_entry_miss", {31'd0, hit_o});
        tick();
        evict_v_i = 1'b0; lookup_v_i = 1'b0;
        lookup_v_i = 1'b1; lookup_tag_i = 28'h13;
        wb_chk(1'b1, 1, 28'h11);
        push_exp("wb_other_hit", 1); pop_cmp("wb_other_hit", {31'd0, hit_o});
        push_exp("wb_other_idx", 3); pop_cmp("wb_other_idx", {30'd0, hit_idx_o});
        tick();
        lookup_v_i = 1'b0;
        wb_ready_i = 1'b1;
        wb_chk(1'b1, 1, 28'h11);
        tick();
        wb_ready_i = 1'b0;
        wb_chk(1'b0, 0, 0);
        tick();
        ins(28'h51, 1'b0, 3);
        ins(28'h52, 1'b0, 1);
        look(28'h14, 1'b1, 0);
        look(28'h30, 1'b1, 2);

        // Fresh start: dirty fill, writeback held off three cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) ins(28'h20 + 28'(i), 1'b1, 32'(i));
        evict_v_i = 1'b1; evict_tag_i = 28'h24; evict_dirty_i = 1'b1;
        wb_chk(1'b0, 0, 0);
        ready_chk(1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            wb_chk(1'b1, 0, 28'h20);
            ready_chk(1'b0, 1'b0);
            tick();
        end
        wb_ready_i = 1'b1;
        wb_chk(1'b1, 0, 28'h20);
        tick();
        wb_ready_i = 1'b0;
        wb_chk(1'b0, 0, 0);
        ready_chk(1'b1, 1'b1);
        push_exp("post_wb_idx", 0); pop_cmp("post_wb_idx", {30'd0, wr_idx_o});
        tick();
        evict_v_i = 1'b0; evict_dirty_i = 1'b0;
        wb_chk(1'b0, 0, 0);
        tick();
        wb_chk(1'b1, 1, 28'h21);

        // Asynchronous reset mid-writeback
        #1 reset = 1'b1;
        #1;
        wb_chk_now();
        tick();
        reset = 1'b0;
        look(28'h22, 1'b0, 0);
        look(28'h24, 1'b0, 0);

        // Same-cycle hit and insert on entry 0 of a full clean cache
        for (int i = 0; i < 4; i++) ins(28'h60 + 28'(i), 1'b0, 32'(i));
        lookup_v_i = 1'b1; lookup_tag_i = 28'h60;
        ins(28'h40, 1'b0, 0);
        lookup_v_i = 1'b0;
        look(28'h40, 1'b1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    task automatic wb_chk_now();
        push_exp("rst_wb_v", 0); pop_cmp("rst_wb_v", {31'd0, wb_v_o});
        push_exp("rst_ready", 1); pop_cmp("rst_ready", {31'd0, evict_ready_o});
    endtask

endmodule
